// File: rtl/demux_mto4m_seq_pkg.sv
// Shared 2048 game types: cell/board typedefs, board geometry and the scatter FSM state enum.
package game_2048_pkg;

    localparam int unsigned CELL_W     = 12;
    localparam int unsigned N          = 4;
    localparam int unsigned CNT_W      = $clog2(N);
    localparam int unsigned NUM_BOARDS = 4;

    typedef logic [CELL_W-1:0]      cell_t;
    typedef cell_t [N-1:0][N-1:0]   board_t;
    typedef logic [1:0]             sel_t;
    typedef logic [CNT_W-1:0]       cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DONE
    } scatter_state_t;

endpackage

// File: rtl/demux_mto4m_seq_if.sv
// Handshake and board bus between a board producer and the sequential board scatter.
interface demux_mto4m_seq_if;

    logic                  valid_i;
    logic                  ready_o;
    game_2048_pkg::sel_t   S;
    game_2048_pkg::board_t IM;
    game_2048_pkg::board_t M0;
    game_2048_pkg::board_t M1;
    game_2048_pkg::board_t M2;
    game_2048_pkg::board_t M3;
    logic                  done_o;

    modport master (
        output valid_i, S, IM,
        input  ready_o, M0, M1, M2, M3, done_o
    );

    modport slave (
        input  valid_i, S, IM,
        output ready_o, M0, M1, M2, M3, done_o
    );

endinterface

// File: rtl/demux_mto4m_seq_mod_counter.sv
// Modulo counter with enable, synchronous clear and a terminal-count flag.
module mod_counter #(
    parameter int unsigned Modulus = 4,
    parameter int unsigned Width   = $clog2(Modulus)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [Width-1:0] cnt,
    output logic             tc
);

    logic [Width-1:0] cnt_q;

    assign cnt = cnt_q;
    assign tc  = (cnt_q == Width'(Modulus - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tc ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/demux_mto4m_seq.sv
// Sequential board scatter: copies one accepted board row by row into destination M0..M3.
// Optional build macro DEMUX_CLEAR_OTHERS_EN zeroes the non-selected boards on the first row write.
module demux_mto4m_seq
    import game_2048_pkg::*;
(
    input logic              clk,
    input logic              rst,
    demux_mto4m_seq_if.slave bus
);

    scatter_state_t state_q;
    board_t         shadow_q;
    sel_t           sel_q;
    board_t         m_q [NUM_BOARDS];
    logic           ready_q;
    logic           done_q;

    cnt_t           row_cnt;
    logic           row_tc;
    logic           accept;
    logic           copying;

    assign accept  = bus.valid_i && ready_q;
    assign copying = (state_q == COPY);

    mod_counter #(
        .Modulus (N),
        .Width   (CNT_W)
    ) u_row_cnt (
        .clk (clk),
        .rst (rst),
        .en  (copying),
        .clr (accept),
        .cnt (row_cnt),
        .tc  (row_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            sel_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            for (int b = 0; b < int'(NUM_BOARDS); b++) begin
                m_q[b] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        // Shadow copies decouple the transfer from later IM/S changes.
                        shadow_q <= bus.IM;
                        sel_q    <= bus.S;
                        ready_q  <= 1'b0;
                        state_q  <= COPY;
                    end
                end
                COPY: begin
`ifdef DEMUX_CLEAR_OTHERS_EN
                    if (row_cnt == '0) begin
                        for (int b = 0; b < int'(NUM_BOARDS); b++) begin
                            if (sel_t'(b) != sel_q) begin
                                m_q[b] <= '0;
                            end
                        end
                    end
`endif
                    m_q[sel_q][row_cnt] <= shadow_q[row_cnt];
                    if (row_tc) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.done_o  = done_q;
    assign bus.M0      = m_q[0];
    assign bus.M1      = m_q[1];
    assign bus.M2      = m_q[2];
    assign bus.M3      = m_q[3];

endmodule
